// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin, burst-bounded two-port arbiter for the data memory port
// Optional feature macro: ARB_IO_PROTECT_EN (blocks port-1 writes to I/O addresses 253..255)
module data_mem_arbiter #(
    parameter int N         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         we0,
    input  logic [N-1:0] addr0,
    input  logic [N-1:0] wdata0,
    output logic         gnt0,
    output logic         rvalid0,
    output logic [N-1:0] rdata0,
    input  logic         req1,
    input  logic         we1,
    input  logic [N-1:0] addr1,
    input  logic [N-1:0] wdata1,
    output logic         gnt1,
    output logic         rvalid1,
    output logic [N-1:0] rdata1,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         mem_we,
    input  logic [N-1:0] mem_rdata,
    output logic         err1
);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          last_served;
    logic          xfer0;
    logic          xfer1;
    logic          at_limit;
    logic          wr_block1;

    assign gnt0     = (state == OWN0);
    assign gnt1     = (state == OWN1);
    assign xfer0    = gnt0 & req0;
    assign xfer1    = gnt1 & req1;
    assign at_limit = (count == LAST_BEAT);

`ifdef ARB_IO_PROTECT_EN
    logic err1_q;

    assign wr_block1 = xfer1 & we1 & (addr1 >= N'(253));
    assign err1      = err1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err1_q <= 1'b0;
        end else begin
            err1_q <= wr_block1;
        end
    end
`else
    assign wr_block1 = 1'b0;
    assign err1      = 1'b0;
`endif

    // Bus is driven only while the owner is actually requesting; otherwise parked at zero.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (xfer0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_we    = we0;
        end else if (xfer1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = we1 & ~wr_block1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last_served)) begin
                        state <= OWN0;
                    end else if (req1) begin
                        state <= OWN1;
                    end
                end
                OWN0: begin
                    // Leave when idle or when the burst limit is hit with the other port waiting.
                    if (!req0 || (at_limit && req1)) begin
                        state       <= req1 ? OWN1 : IDLE;
                        last_served <= 1'b0;
                        count       <= '0;
                    end else if (!at_limit) begin
                        count <= count + 1'b1;
                    end
                end
                OWN1: begin
                    if (!req1 || (at_limit && req0)) begin
                        state       <= req0 ? OWN0 : IDLE;
                        last_served <= 1'b1;
                        count       <= '0;
                    end else if (!at_limit) begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= xfer0 & ~we0;
            rvalid1 <= xfer1 & ~we1;
            if (xfer0 && !we0) begin
                rdata0 <= mem_rdata;
            end
            if (xfer1 && !we1) begin
                rdata1 <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - table-driven bench for data_mem_arbiter with a behavioural RAM
// Expected values adapt to ARB_IO_PROTECT_EN when it is defined for the build.
module tb_data_mem_arbiter;
`ifdef ARB_IO_PROTECT_EN
    localparam logic P = 1'b1;
`else
    localparam logic P = 1'b0;
`endif

    typedef struct packed {
        logic        rst_n;
        logic        req0;
        logic        we0;
        logic [7:0]  addr0;
        logic [7:0]  wdata0;
        logic        req1;
        logic        we1;
        logic [7:0]  addr1;
        logic [7:0]  wdata1;
        logic [37:0] exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_we, err1;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [7:0] ram [256];

    vec_t tab[$];
    int   n_vec = 0;
    int   n_bad = 0;

    data_mem_arbiter #(.N(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .err1(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    always @(negedge clk) begin
        n_vec++;
        if (gnt0 && gnt1) begin
            n_bad++;
            $display("FAIL excl_grant at %0t: gnt0=%b gnt1=%b, required not both high", $time, gnt0, gnt1);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rs, input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                       input logic g0, input logic g1, input logic mwe, input logic [7:0] ma, input logic [7:0] mwd,
                       input logic rv0, input logic [7:0] rd0, input logic rv1, input logic [7:0] rd1, input logic er);
        vec_t v;
        v.rst_n = rs; v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
        v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
        v.exp = {g0, g1, mwe, ma, mwd, rv0, rd0, rv1, rd1, er};
        tab.push_back(v);
    endtask

    task automatic run_tab(input string tag);
        logic [37:0] act;
        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk);
            rst_n = tab[i].rst_n;
            req0 = tab[i].req0; we0 = tab[i].we0; addr0 = tab[i].addr0; wdata0 = tab[i].wdata0;
            req1 = tab[i].req1; we1 = tab[i].we1; addr1 = tab[i].addr1; wdata1 = tab[i].wdata1;
            #1;
            act = {gnt0, gnt1, mem_we, mem_addr, mem_wdata, rvalid0, rdata0, rvalid1, rdata1, err1};
            check($sformatf("%s[%0d] {g0,g1,we,addr,wd,rv0,rd0,rv1,rd1,err}", tag, i), 64'(act), 64'(tab[i].exp));
        end
        tab.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[10] = 8'h5A; ram[20] = 8'hA0; ram[30] = 8'hB0; ram[253] = 8'h01; ram[254] = 8'h81;

        // rst r0 w0 a0 d0 | r1 w1 a1 d1 || g0 g1 we maddr mwd | rv0 rd0 | rv1 rd1 | err
        add(0, 0,0,8'd0,8'h00,  0,0,8'd0,8'h00,  0,0,0,8'd0,8'h00,  0,8'h00, 0,8'h00, 0);
        // single port-0 read of RAM[10]
        add(1, 1,0,8'd10,8'h00, 0,0,8'd0,8'h00,  0,0,0,8'd0,8'h00,  0,8'h00, 0,8'h00, 0);
        add(1, 1,0,8'd10,8'h00, 0,0,8'd0,8'h00,  1,0,0,8'd10,8'h00, 0,8'h00, 0,8'h00, 0);
        add(1, 0,0,8'd10,8'h00, 0,0,8'd0,8'h00,  1,0,0,8'd0,8'h00,  1,8'h5A, 0,8'h00, 0);
        add(1, 0,0,8'd0,8'h00,  0,0,8'd0,8'h00,  0,0,0,8'd0,8'h00,  0,8'h5A, 0,8'h00, 0);
        // reset, then tie from IDLE: port 0 first, handoff after 4 transfers
        add(0, 0,0,8'd0,8'h00,  0,0,8'd0,8'h00,  0,0,0,8'd0,8'h00,  0,8'h00, 0,8'h00, 0);
        add(1, 1,0,8'd20,8'h00, 1,0,8'd30,8'h00, 0,0,0,8'd0,8'h00,  0,8'h00, 0,8'h00, 0);
        add(1, 1,0,8'd20,8'h00, 1,0,8'd30,8'h00, 1,0,0,8'd20,8'h00, 0,8'h00, 0,8'h00, 0);
        add(1, 1,0,8'd20,8'h00, 1,0,8'd30,8'h00, 1,0,0,8'd20,8'h00, 1,8'hA0, 0,8'h00, 0);
        add(1, 1,0,8'd20,8'h00, 1,0,8'd30,8'h00, 1,0,0,8'd20,8'h00, 1,8'hA0, 0,8'h00, 0);
        add(1, 1,0,8'd20,8'h00, 1,0,8'd30,8'h00, 1,0,0,8'd20,8'h00, 1,8'hA0, 0,8'h00, 0);
        add(1, 0,0,8'd20,8'h00, 1,0,8'd30,8'h00, 0,1,0,8'd30,8'h00, 1,8'hA0, 0,8'h00, 0);
        add(1, 0,0,8'd0,8'h00,  0,0,8'd30,8'h00, 0,1,0,8'd0,8'h00,  0,8'hA0, 1,8'hB0, 0);
        add(1, 0,0,8'd0,8'h00,  0,0,8'd0,8'h00,  0,0,0,8'd0,8'h00,  0,8'hA0, 0,8'hB0, 0);
        // port 1 alone writes 5 words: no handoff, count saturates
        add(1, 0,0,8'd0,8'h00,  1,1,8'd0,8'h11,  0,0,0,8'd0,8'h00,  0,8'hA0, 0,8'hB0, 0);
        add(1, 0,0,8'd0,8'h00,  1,1,8'd0,8'h11,  0,1,1,8'd0,8'h11,  0,8'hA0, 0,8'hB0, 0);
        add(1, 0,0,8'd0,8'h00,  1,1,8'd1,8'h22,  0,1,1,8'd1,8'h22,  0,8'hA0, 0,8'hB0, 0);
        add(1, 0,0,8'd0,8'h00,  1,1,8'd2,8'h33,  0,1,1,8'd2,8'h33,  0,8'hA0, 0,8'hB0, 0);
        add(1, 0,0,8'd0,8'h00,  1,1,8'd3,8'h44,  0,1,1,8'd3,8'h44,  0,8'hA0, 0,8'hB0, 0);
        add(1, 0,0,8'd0,8'h00,  1,1,8'd4,8'h55,  0,1,1,8'd4,8'h55,  0,8'hA0, 0,8'hB0, 0);
        add(1, 0,0,8'd0,8'h00,  0,1,8'd4,8'h55,  0,1,0,8'd0,8'h00,  0,8'hA0, 0,8'hB0, 0);
        // readback through port 0
        add(1, 1,0,8'd0,8'h00,  0,0,8'd0,8'h00,  0,0,0,8'd0,8'h00,  0,8'hA0, 0,8'hB0, 0);
        add(1, 1,0,8'd0,8'h00,  0,0,8'd0,8'h00,  1,0,0,8'd0,8'h00,  0,8'hA0, 0,8'hB0, 0);
        add(1, 1,0,8'd1,8'h00,  0,0,8'd0,8'h00,  1,0,0,8'd1,8'h00,  1,8'h11, 0,8'hB0, 0);
        add(1, 1,0,8'd2,8'h00,  0,0,8'd0,8'h00,  1,0,0,8'd2,8'h00,  1,8'h22, 0,8'hB0, 0);
        add(1, 1,0,8'd3,8'h00,  0,0,8'd0,8'h00,  1,0,0,8'd3,8'h00,  1,8'h33, 0,8'hB0, 0);
        add(1, 1,0,8'd4,8'h00,  0,0,8'd0,8'h00,  1,0,0,8'd4,8'h00,  1,8'h44, 0,8'hB0, 0);
        add(1, 0,0,8'd0,8'h00,  0,0,8'd0,8'h00,  1,0,0,8'd0,8'h00,  1,8'h55, 0,8'hB0, 0);
        add(1, 0,0,8'd0,8'h00,  0,0,8'd0,8'h00,  0,0,0,8'd0,8'h00,  0,8'h55, 0,8'hB0, 0);
        // owner 0 drops mid-burst with port 1 waiting, later tie goes to port 0
        add(1, 1,0,8'd10,8'h00, 0,0,8'd0,8'h00,  0,0,0,8'd0,8'h00,  0,8'h55, 0,8'hB0, 0);
        add(1, 1,0,8'd10,8'h00, 1,0,8'd30,8'h00, 1,0,0,8'd10,8'h00, 0,8'h55, 0,8'hB0, 0);
        add(1, 1,0,8'd10,8'h00, 1,0,8'd30,8'h00, 1,0,0,8'd10,8'h00, 1,8'h5A, 0,8'hB0, 0);
        add(1, 0,0,8'd10,8'h00, 1,0,8'd30,8'h00, 1,0,0,8'd0,8'h00,  1,8'h5A, 0,8'hB0, 0);
        add(1, 0,0,8'd0,8'h00,  1,0,8'd30,8'h00, 0,1,0,8'd30,8'h00, 0,8'h5A, 0,8'hB0, 0);
        add(1, 0,0,8'd0,8'h00,  0,0,8'd30,8'h00, 0,1,0,8'd0,8'h00,  0,8'h5A, 1,8'hB0, 0);
        add(1, 1,0,8'd20,8'h00, 1,0,8'd30,8'h00, 0,0,0,8'd0,8'h00,  0,8'h5A, 0,8'hB0, 0);
        add(1, 0,0,8'd20,8'h00, 0,0,8'd30,8'h00, 1,0,0,8'd0,8'h00,  0,8'h5A, 0,8'hB0, 0);
        add(1, 0,0,8'd0,8'h00,  0,0,8'd0,8'h00,  0,0,0,8'd0,8'h00,  0,8'h5A, 0,8'hB0, 0);
        run_tab("A");

        // reset asserted in the middle of a port-1 write must drop the bus with no clock edge
        @(negedge clk);
        req1 = 1; we1 = 1; addr1 = 8'd5; wdata1 = 8'h66;
        @(negedge clk);
        #1;
        check("own1_write {gnt1,we,addr}", 64'({gnt1, mem_we, mem_addr}), 64'({1'b1, 1'b1, 8'd5}));
        rst_n = 1'b0;
        #1;
        check("async_rst {gnt0,gnt1,we,addr}", 64'({gnt0, gnt1, mem_we, mem_addr}), 64'd0);
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst {g0,g1,rv0,rv1,rd0,rd1,err}", 64'({gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err1}), 64'd0);
        check("no_write ram[5]", 64'(ram[5]), 64'h00);

        // I/O protection: port 1 write to 253, then port 0 read/write/read and a button read at 254
        add(1, 0,0,8'd0,8'h00,    1,1,8'd253,8'h7E, 0,0,0,8'd0,8'h00,      0,8'h00, 0,8'h00, 0);
        add(1, 0,0,8'd0,8'h00,    1,1,8'd253,8'h7E, 0,1,!P,8'd253,8'h7E,   0,8'h00, 0,8'h00, 0);
        add(1, 0,0,8'd0,8'h00,    0,0,8'd0,8'h00,   0,1,0,8'd0,8'h00,      0,8'h00, 0,8'h00, P);
        add(1, 1,0,8'd253,8'h00,  0,0,8'd0,8'h00,   0,0,0,8'd0,8'h00,      0,8'h00, 0,8'h00, 0);
        add(1, 1,0,8'd253,8'h00,  0,0,8'd0,8'h00,   1,0,0,8'd253,8'h00,    0,8'h00, 0,8'h00, 0);
        add(1, 1,1,8'd253,8'h7E,  0,0,8'd0,8'h00,   1,0,1,8'd253,8'h7E,    1,(P ? 8'h01 : 8'h7E), 0,8'h00, 0);
        add(1, 1,0,8'd253,8'h00,  0,0,8'd0,8'h00,   1,0,0,8'd253,8'h00,    0,(P ? 8'h01 : 8'h7E), 0,8'h00, 0);
        add(1, 1,0,8'd254,8'h00,  0,0,8'd0,8'h00,   1,0,0,8'd254,8'h00,    1,8'h7E, 0,8'h00, 0);
        add(1, 0,0,8'd0,8'h00,    0,0,8'd0,8'h00,   1,0,0,8'd0,8'h00,      1,8'h81, 0,8'h00, 0);
        add(1, 0,0,8'd0,8'h00,    0,0,8'd0,8'h00,   0,0,0,8'd0,8'h00,      0,8'h81, 0,8'h00, 0);
        run_tab("B");

        check("display ram[253]", 64'(ram[253]), 64'h7E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
